// File: rtl/single_store_pkg.sv
// rtl/single_store_pkg.sv - shared widths, FSM states and store constants
package single_store_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 16;
  localparam int IDX_W  = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] STORE_ADDR  = '0;
  localparam logic [DATA_W-1:0] STORE_VALUE = 32'd5;

  typedef enum logic [1:0] {S0, S1, S2, S3} state_e;
endpackage

// File: rtl/single_store_system_if.sv
// rtl/single_store_system_if.sv - read/debug/observability bundle of the store system
interface single_store_system_if;
  import single_store_pkg::*;

  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data;
  logic              valid;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wen;

  modport slave (
    input  raddr, debug_addr,
    output rdata, debug_data, valid, waddr, wdata, wen
  );

  modport master (
    output raddr, debug_addr,
    input  rdata, debug_data, valid, waddr, wdata, wen
  );
endinterface

// File: rtl/ram.sv
// rtl/ram.sv - unreset word store with registered read port and combinational debug port
module RAM
  import single_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] debug_addr,
  output logic [DATA_W-1:0] debug_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wen && (waddr < ADDR_W'(DEPTH)))
      mem_q[waddr[IDX_W-1:0]] <= wdata;
  end

  // Same-edge read returns the pre-write word
  always_ff @(posedge clk) begin
    if (rst)
      rdata <= '0;
    else if (raddr < ADDR_W'(DEPTH))
      rdata <= mem_q[raddr[IDX_W-1:0]];
    else
      rdata <= '0;
  end

  always_comb begin
    debug_data = '0;
    if (debug_addr < ADDR_W'(DEPTH))
      debug_data = mem_q[debug_addr[IDX_W-1:0]];
  end
endmodule

// File: rtl/single_store.sv
// rtl/single_store.sv - four-state kernel that writes one constant word, then holds valid
module single_store
  import single_store_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  output logic              valid,
  output logic [ADDR_W-1:0] waddr_0,
  output logic [DATA_W-1:0] wdata_0,
  output logic              wen_0
);
  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    waddr_0 = '0;
    wdata_0 = '0;
    wen_0   = 1'b0;
    case (state_q)
      S0: state_d = S1;
      S1: state_d = S2;
      S2: begin
        state_d = S3;
        // rst gates the write so a reset taken in S2 leaves memory untouched
        if (!rst) begin
          wen_0   = 1'b1;
          waddr_0 = STORE_ADDR;
          wdata_0 = STORE_VALUE;
        end
      end
      S3: begin
        state_d = S3;
        valid   = 1'b1;
      end
      default: state_d = S0;
    endcase
  end
endmodule

// File: rtl/single_store_system.sv
// rtl/single_store_system.sv - store-one-word kernel wired to its memory
module single_store_system
  import single_store_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  single_store_system_if.slave        bus
);
  single_store u_fsm (
    .clk     (clk),
    .rst     (rst),
    .valid   (bus.valid),
    .waddr_0 (bus.waddr),
    .wdata_0 (bus.wdata),
    .wen_0   (bus.wen)
  );

  RAM u_ram (
    .clk        (clk),
    .rst        (rst),
    .raddr      (bus.raddr),
    .rdata      (bus.rdata),
    .wen        (bus.wen),
    .wdata      (bus.wdata),
    .waddr      (bus.waddr),
    .debug_addr (bus.debug_addr),
    .debug_data (bus.debug_data)
  );
endmodule

// File: tb/tb_single_store_system.sv
// tb/tb_single_store_system.sv - table-driven and randomized checks of the store system
module tb_single_store_system;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  single_store_system_if bus();

  single_store_system dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // mode: 0 = not checked (unwritten word), 1 = must equal, 2 = must differ
  typedef struct {
    logic        rst;
    logic [4:0]  raddr;
    logic [4:0]  dbg;
    logic        valid;
    logic        wen;
    logic [31:0] wdata;
    int          dmode;
    logic [31:0] dexp;
    int          rmode;
    logic [31:0] rexp;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int mode, input logic [31:0] act, input logic [31:0] exp);
    if (mode == 1) begin
      n_checks++;
      if (act !== exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end else if (mode == 2) begin
      n_checks++;
      if (act === exp) begin
        n_errors++;
        $display("FAIL %s: got %h expected anything but %h", name, act, exp);
      end
    end
  endtask

  task automatic step(input logic r, input logic [4:0] ra, input logic [4:0] da);
    rst            = r;
    bus.raddr      = ra;
    bus.debug_addr = da;
    @(posedge clk);
    #1;
  endtask

  int          cnt;
  logic [4:0]  ra, da;
  logic        r;
  int          rm;
  logic [31:0] rx;
  int          dm;
  logic [31:0] dx;

  initial begin
    bus.raddr      = '0;
    bus.debug_addr = '0;
    //          rst raddr dbg  valid wen wdata  dm dexp rm rexp
    tbl[0]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 2, 32'd5, 1, 32'd0};
    tbl[1]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 2, 32'd5, 2, 32'd5};
    tbl[2]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 32'd5, 2, 32'd5, 2, 32'd5};
    tbl[3]  = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 2, 32'd5, 1, 32'd0};
    tbl[4]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 2, 32'd5, 2, 32'd5};
    tbl[5]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 32'd5, 2, 32'd5, 2, 32'd5};
    tbl[6]  = '{1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'd0, 1, 32'd5, 2, 32'd5};
    tbl[7]  = '{1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'd0, 1, 32'd5, 1, 32'd5};
    tbl[8]  = '{1'b0, 5'd3,  5'd20, 1'b1, 1'b0, 32'd0, 1, 32'd0, 0, 32'd0};
    tbl[9]  = '{1'b0, 5'd20, 5'd31, 1'b1, 1'b0, 32'd0, 1, 32'd0, 1, 32'd0};
    tbl[10] = '{1'b0, 5'd16, 5'd16, 1'b1, 1'b0, 32'd0, 1, 32'd0, 1, 32'd0};
    tbl[11] = '{1'b1, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 1, 32'd5, 1, 32'd0};
    tbl[12] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 32'd0, 1, 32'd5, 1, 32'd5};
    tbl[13] = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b1, 32'd5, 1, 32'd5, 1, 32'd5};
    tbl[14] = '{1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 32'd0, 1, 32'd5, 1, 32'd5};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].raddr, tbl[i].dbg);
      chk($sformatf("row%0d valid", i), 1, {31'd0, bus.valid}, {31'd0, tbl[i].valid});
      chk($sformatf("row%0d wen", i),   1, {31'd0, bus.wen},   {31'd0, tbl[i].wen});
      chk($sformatf("row%0d waddr", i), 1, {27'd0, bus.waddr}, 32'd0);
      chk($sformatf("row%0d wdata", i), 1, bus.wdata, tbl[i].wdata);
      chk($sformatf("row%0d debug", i), tbl[i].dmode, bus.debug_data, tbl[i].dexp);
      chk($sformatf("row%0d rdata", i), tbl[i].rmode, bus.rdata, tbl[i].rexp);
    end

    // Reference: edges since last reset, saturating at 3; word 0 holds 5 from here on
    cnt = 3;
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 9) == 0);
      ra = 5'($urandom_range(0, 31));
      da = 5'($urandom_range(0, 31));
      if (r)              begin rm = 1; rx = 0; end
      else if (ra >= 16)  begin rm = 1; rx = 0; end
      else if (ra == 0)   begin rm = 1; rx = 5; end
      else                begin rm = 0; rx = 0; end
      if (da >= 16)       begin dm = 1; dx = 0; end
      else if (da == 0)   begin dm = 1; dx = 5; end
      else                begin dm = 0; dx = 0; end
      cnt = r ? 0 : ((cnt < 3) ? cnt + 1 : 3);
      step(r, ra, da);
      chk($sformatf("rnd%0d valid", i), 1, {31'd0, bus.valid}, (cnt == 3) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d wen", i),   1, {31'd0, bus.wen}, (cnt == 2 && !r) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d wdata", i), 1, bus.wdata, (cnt == 2 && !r) ? 32'd5 : 32'd0);
      chk($sformatf("rnd%0d debug", i), dm, bus.debug_data, dx);
      chk($sformatf("rnd%0d rdata", i), rm, bus.rdata, rx);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
